serial_add_ctrl: RTL and testbench

Bit-serial adder sequencer. It time-shares one external 1-bit full-adder cell (a, b, cin -> s, co) to add two WIDTH-bit operands, LSB first, one bit per clock. It holds the operand shift registers, the carry flip-flop, the bit counter and the start/done handshake. The top level wires the fa_* ports directly to a full-adder cell instance. It is the arithmetic helper used by the serial datapath, for example checksum and parity accumulation alongside the UART.

---
 rtl/serial_add_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: drives one external full-adder cell LSB first,
// one bit per clock, and reports sum, unsigned carry-out and signed overflow.
module serial_add_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_s,
   input  logic             fa_co,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sh, a_sh_nx;
   logic [WIDTH-1:0] b_sh, b_sh_nx;
   logic [WIDTH-1:0] sum_sh, sum_sh_nx;
   logic [WIDTH-1:0] sum_nx;
   logic             carry, carry_nx;
   logic             msb_cin, msb_cin_nx;
   logic             cout_nx, overflow_nx;
   logic [CW-1:0]    cnt, cnt_nx;

   // Status flags are direct decodes of the state register
   assign busy = (state == ST_ADD);
   assign done = (state == ST_DONE);

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         sum_sh   <= '0;
         sum      <= '0;
         carry    <= 1'b0;
         msb_cin  <= 1'b0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         cnt      <= '0;
      end else begin
         state    <= state_nx;
         a_sh     <= a_sh_nx;
         b_sh     <= b_sh_nx;
         sum_sh   <= sum_sh_nx;
         sum      <= sum_nx;
         carry    <= carry_nx;
         msb_cin  <= msb_cin_nx;
         cout     <= cout_nx;
         overflow <= overflow_nx;
         cnt      <= cnt_nx;
      end
   end

   // Next-state, datapath update and full-adder drive
   always_comb begin
      state_nx    = state;
      a_sh_nx     = a_sh;
      b_sh_nx     = b_sh;
      sum_sh_nx   = sum_sh;
      sum_nx      = sum;
      carry_nx    = carry;
      msb_cin_nx  = msb_cin;
      cout_nx     = cout;
      overflow_nx = overflow;
      cnt_nx      = cnt;
      fa_a        = 1'b0;
      fa_b        = 1'b0;
      fa_cin      = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               a_sh_nx   = a;
               b_sh_nx   = b;
               carry_nx  = cin;
               sum_sh_nx = '0;
               cnt_nx    = '0;
               state_nx  = ST_ADD;
            end
         end
         ST_ADD: begin
            fa_a      = a_sh[0];
            fa_b      = b_sh[0];
            fa_cin    = carry;
            a_sh_nx   = a_sh >> 1;
            b_sh_nx   = b_sh >> 1;
            sum_sh_nx = {fa_s, sum_sh[WIDTH-1:1]};
            carry_nx  = fa_co;
            cnt_nx    = cnt + CW'(1);
            // Carry out of bit WIDTH-2 is the carry into the MSB
            if (cnt == CW'(WIDTH - 2)) begin
               msb_cin_nx = fa_co;
            end
            if (cnt == CW'(WIDTH - 1)) begin
               sum_nx      = {fa_s, sum_sh[WIDTH-1:1]};
               cout_nx     = fa_co;
               overflow_nx = msb_cin ^ fa_co;
               state_nx    = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=8 and WIDTH=4 instances, each wired
// to a behavioural full-adder cell on its fa_* ports.
module tb_serial_add_ctrl;

   logic       clk;
   logic       rst_n;
   int         checks;
   int         errors;

   // WIDTH=8 instance
   logic       start8, cin8, fa_a8, fa_b8, fa_cin8, fa_s8, fa_co8;
   logic       busy8, done8, cout8, ovf8;
   logic [7:0] a8, b8, sum8;

   // WIDTH=4 instance
   logic       start4, cin4, fa_a4, fa_b4, fa_cin4, fa_s4, fa_co4;
   logic       busy4, done4, cout4, ovf4;
   logic [3:0] a4, b4, sum4;

   assign fa_s8  = fa_a8 ^ fa_b8 ^ fa_cin8;
   assign fa_co8 = (fa_a8 & fa_b8) | (fa_a8 & fa_cin8) | (fa_b8 & fa_cin8);
   assign fa_s4  = fa_a4 ^ fa_b4 ^ fa_cin4;
   assign fa_co4 = (fa_a4 & fa_b4) | (fa_a4 & fa_cin4) | (fa_b4 & fa_cin4);

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_s(fa_s8), .fa_co(fa_co8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
   );

   serial_add_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .fa_a(fa_a4), .fa_b(fa_b4), .fa_cin(fa_cin4), .fa_s(fa_s4), .fa_co(fa_co4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One 8-bit add from IDLE; operands are scrambled right after capture
   task automatic add8(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                       input logic [7:0] es, input logic ec, input logic eo,
                       input string tag);
      int nb;
      a8 = va; b8 = vb; cin8 = vc; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0; a8 = ~va; b8 = ~vb; cin8 = ~vc;
      nb = 0;
      while (busy8 && nb < 40) begin
         nb++;
         @(posedge clk); #1;
      end
      chk({tag, "_busycyc"}, 32'(nb), 32'd8);
      chk({tag, "_done"}, 32'(done8), 32'd1);
      chk({tag, "_sum"}, 32'(sum8), 32'(es));
      chk({tag, "_cout"}, 32'(cout8), 32'(ec));
      chk({tag, "_ovf"}, 32'(ovf8), 32'(eo));
      chk({tag, "_fa_done"}, 32'({fa_a8, fa_b8, fa_cin8}), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_done_low"}, 32'(done8), 32'd0);
   endtask

   task automatic add4(input logic [3:0] va, input logic [3:0] vb, input logic vc);
      int          nb;
      logic [4:0]  full;
      logic        eo;
      full = 5'(va) + 5'(vb) + 5'(vc);
      eo   = (va[3] == vb[3]) && (full[3] != va[3]);
      a4 = va; b4 = vb; cin4 = vc; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0; a4 = ~va; b4 = ~vb;
      nb = 0;
      while (busy4 && nb < 20) begin
         nb++;
         @(posedge clk); #1;
      end
      chk("w4_busycyc", 32'(nb), 32'd4);
      chk("w4_done", 32'(done4), 32'd1);
      chk("w4_sum", 32'(sum4), 32'(full[3:0]));
      chk("w4_cout", 32'(cout4), 32'(full[4]));
      chk("w4_ovf", 32'(ovf4), 32'(eo));
      @(posedge clk); #1;
   endtask

   logic [7:0] bva [3];
   logic [7:0] bvb [3];
   logic [7:0] bes [3];
   logic       bec [3];
   logic       beo [3];

   initial begin
      int nd;
      checks = 0; errors = 0;
      rst_n = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_sum", 32'(sum8), 32'd0);
      chk("rst_cout_ovf", 32'({cout8, ovf8}), 32'd0);
      chk("rst_fa", 32'({fa_a8, fa_b8, fa_cin8}), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      add8(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, "a35_4a");
      add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "aff_01");
      add8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "a7f_01");
      add8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "a80_80");

      // Carry-in only: fa_cin high on bit 0, then low
      chk("idle_fa", 32'({fa_a8, fa_b8, fa_cin8}), 32'd0);
      a8 = 8'h00; b8 = 8'h00; cin8 = 1'b1; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      chk("cin_fa_bit0", 32'({fa_a8, fa_b8, fa_cin8}), 32'b001);
      @(posedge clk); #1;
      chk("cin_fa_bit1", 32'({fa_a8, fa_b8, fa_cin8}), 32'b000);
      nd = 0;
      while (!done8 && nd < 40) begin
         nd++;
         @(posedge clk); #1;
      end
      chk("cin_done", 32'(done8), 32'd1);
      chk("cin_sum", 32'(sum8), 32'h01);
      chk("cin_cout", 32'(cout8), 32'd0);
      @(posedge clk); #1;

      // start held high: back-to-back operations, operands scrambled while busy
      bva[0] = 8'h10; bvb[0] = 8'h20; bes[0] = 8'h30; bec[0] = 1'b0; beo[0] = 1'b0;
      bva[1] = 8'hC8; bvb[1] = 8'h64; bes[1] = 8'h2C; bec[1] = 1'b1; beo[1] = 1'b0;
      bva[2] = 8'h50; bvb[2] = 8'h50; bes[2] = 8'hA0; bec[2] = 1'b0; beo[2] = 1'b1;
      nd = 0;
      start8 = 1'b1; a8 = bva[0]; b8 = bvb[0]; cin8 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("b2b_busy", 32'(busy8), 32'd1);
         repeat (8) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            @(posedge clk); #1;
            if (done8) nd++;
         end
         chk("b2b_done", 32'(done8), 32'd1);
         chk("b2b_sum", 32'(sum8), 32'(bes[k]));
         chk("b2b_cout", 32'(cout8), 32'(bec[k]));
         chk("b2b_ovf", 32'(ovf8), 32'(beo[k]));
         if (k < 2) begin
            a8 = bva[k+1]; b8 = bvb[k+1]; cin8 = 1'b0;
         end else begin
            start8 = 1'b0;
         end
         @(posedge clk); #1;
         chk("b2b_idle", 32'({busy8, done8}), 32'd0);
      end
      chk("b2b_ndone", 32'(nd), 32'd3);

      // Asynchronous reset at bit 4 abandons the add
      a8 = 8'hAA; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy8), 32'd0);
      chk("arst_done", 32'(done8), 32'd0);
      chk("arst_sum", 32'(sum8), 32'd0);
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      nd = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done8 || busy8) nd++;
      end
      chk("arst_no_done", 32'(nd), 32'd0);
      add8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "a12_34");

      // WIDTH=4 instance: edge vectors then a compact pseudo-random sweep
      add4(4'hF, 4'h0, 1'b1);
      add4(4'h7, 4'h1, 1'b0);
      add4(4'h8, 4'h8, 1'b0);
      for (int i = 0; i < 40; i++) begin
         add4(4'($urandom), 4'($urandom), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
